// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: validates decoded 16-bit SPI frames and either commits a write
// to the PWM configuration register bank or returns a register read.
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   frame_valid/_data   - incoming frame: [15]=write, [14:8]=addr, [7:0]=data
//   frame_ready         - high only while idle (frame can be accepted)
//   rd_data/rd_valid    - read result, rd_valid is a one-cycle pulse
//   wr_pulse/err_pulse  - one-cycle write / rejected-frame indications
//   err_count           - saturating count of rejected frames
//   en_out_lo..pwm_duty - register bank contents (regs 0..4)
module spi_reg_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned MAX_ADDR = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    input  logic [15:0]       frame_data,
    output logic              frame_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_pulse,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [DATA_W-1:0] en_out_lo,
    output logic [DATA_W-1:0] en_out_hi,
    output logic [DATA_W-1:0] en_pwm_lo,
    output logic [DATA_W-1:0] en_pwm_hi,
    output logic [DATA_W-1:0] pwm_duty
);

    localparam int unsigned     NUM_REGS   = MAX_ADDR + 1;
    localparam logic [ADDR_W-1:0] MAX_ADDR_C = ADDR_W'(MAX_ADDR);

    // 2'b10 is deliberately unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_VALID  = 2'b01,
        ST_UPDATE = 2'b11
    } state_t;

    state_t            r_state;
    logic [15:0]       r_frame_q;
    logic [DATA_W-1:0] r_bank [NUM_REGS];

    logic              w_is_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rd_mux;

    assign w_is_wr = r_frame_q[15];
    assign w_addr  = r_frame_q[8 +: ADDR_W];
    assign w_wdata = r_frame_q[DATA_W-1:0];

    // Read-back mux over the implemented registers
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_addr == ADDR_W'(i)) begin
                w_rd_mux = r_bank[i];
            end
        end
    end

    assign en_out_lo = r_bank[0];
    assign en_out_hi = r_bank[1];
    assign en_pwm_lo = r_bank[2];
    assign en_pwm_hi = r_bank[3];
    assign pwm_duty  = r_bank[4];

    // Frame sequencer: IDLE -> VALIDATION -> UPDATE, all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_frame_q   <= '0;
            frame_ready <= 1'b1;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            wr_pulse    <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            rd_valid  <= 1'b0;
            wr_pulse  <= 1'b0;
            err_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_valid && frame_ready) begin
                        r_frame_q   <= frame_data;
                        r_state     <= ST_VALID;
                        frame_ready <= 1'b0;
                    end
                end
                ST_VALID: begin
                    if (w_addr <= MAX_ADDR_C) begin
                        r_state <= ST_UPDATE;
                    end else begin
                        err_pulse <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        r_state     <= ST_IDLE;
                        frame_ready <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (w_is_wr) begin
                        for (int i = 0; i < int'(NUM_REGS); i++) begin
                            if (w_addr == ADDR_W'(i)) begin
                                r_bank[i] <= w_wdata;
                            end
                        end
                        wr_pulse <= 1'b1;
                    end else begin
                        rd_data  <= w_rd_mux;
                        rd_valid <= 1'b1;
                    end
                    r_state     <= ST_IDLE;
                    frame_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    frame_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Testbench for spi_reg_ctrl: randomized frames against a register-bank model,
// expected responses queued by the driver and checked by an independent monitor.
module tb_spi_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic [15:0] frame_data;
    logic        frame_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        wr_pulse;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [7:0]  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, pwm_duty;

    spi_reg_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_ready (frame_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_pulse    (wr_pulse),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .en_out_lo   (en_out_lo),
        .en_out_hi   (en_out_hi),
        .en_pwm_lo   (en_pwm_lo),
        .en_pwm_hi   (en_pwm_hi),
        .pwm_duty    (pwm_duty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // kind: 3'b001 write, 3'b010 read, 3'b100 error
    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] edge_n;
        logic [7:0]  rd;
        logic [7:0]  err;
        logic [39:0] regs;
    } exp_t;

    exp_t q[$];

    logic [7:0] m_regs [5];
    logic [7:0] m_err;
    logic [7:0] m_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] model_flat();
        return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic logic [39:0] dut_flat();
        return {pwm_duty, en_pwm_hi, en_pwm_lo, en_out_hi, en_out_lo};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        m_err = 8'h00;
        m_rd  = 8'h00;
    endtask

    // Present one frame, hold it until accepted, and queue the expected response.
    // Returns with frame_valid still high so back-to-back frames keep it asserted.
    task automatic send(input logic [15:0] f, input bit expect_it);
        int   waits;
        int   a;
        bit   good;
        exp_t e;
        @(negedge clk);
        waits = 0;
        while (!frame_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("ready_hi", 64'(frame_ready), 64'd1);
        if (!frame_ready) return;
        frame_valid = 1'b1;
        frame_data  = f;
        a    = int'(f[14:8]);
        good = (a <= 4);
        if (expect_it) begin
            e.edge_n = 32'(cyc + 1);
            if (good) begin
                if (f[15]) begin
                    m_regs[a] = f[7:0];
                    e.kind = 3'b001;
                end else begin
                    m_rd   = m_regs[a];
                    e.kind = 3'b010;
                end
                e.edge_n = e.edge_n + 32'd2;
            end else begin
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
                e.kind   = 3'b100;
                e.edge_n = e.edge_n + 32'd1;
            end
            e.rd   = m_rd;
            e.err  = m_err;
            e.regs = model_flat();
            q.push_back(e);
        end
        @(negedge clk);
        check("ready_lo1", 64'(frame_ready), 64'd0);
        if (good) begin
            @(negedge clk);
            check("ready_lo2", 64'(frame_ready), 64'd0);
        end
    endtask

    task automatic drain();
        int n;
        frame_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Monitor: pops an expectation for each response pulse, flags missed ones
    always @(negedge clk) begin
        logic [2:0] got;
        exp_t       e;
        got = {err_pulse, rd_valid, wr_pulse};
        if (got != 3'b000) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", 64'(got), 64'd0);
            end else begin
                e = q.pop_front();
                check("pulse_kind", 64'(got), 64'(e.kind));
                check("pulse_cycle", 64'(cyc), 64'(e.edge_n));
                check("rd_data", 64'(rd_data), 64'(e.rd));
                check("err_count", 64'(err_count), 64'(e.err));
                check("regs", 64'(dut_flat()), 64'(e.regs));
                check("ready_after", 64'(frame_ready), 64'd1);
            end
        end else if (q.size() != 0 && cyc > int'(q[0].edge_n)) begin
            e = q.pop_front();
            check("missing_pulse", 64'(got), 64'(e.kind));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] f;
        rst         = 1'b1;
        frame_valid = 1'b0;
        frame_data  = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_regs", 64'(dut_flat()), 64'd0);
        check("reset_ready", 64'(frame_ready), 64'd1);
        check("reset_misc", 64'({rd_data, rd_valid, wr_pulse, err_pulse, err_count}), 64'd0);

        // Directed: duty write, write then read of reg 0, bad address
        send(16'h8455, 1'b1);
        send(16'h80F0, 1'b1);
        send(16'h0000, 1'b1);
        send(16'h8512, 1'b1);
        drain();
        check("dir_duty", 64'(pwm_duty), 64'h55);
        check("dir_reg0", 64'(en_out_lo), 64'hF0);
        check("dir_rd", 64'(rd_data), 64'hF0);
        check("dir_err1", 64'(err_count), 64'd1);
        check("dir_others", 64'({en_out_hi, en_pwm_lo, en_pwm_hi}), 64'd0);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            f = {1'b1, 7'(32'($urandom_range(5, 127))), 8'($urandom)};
            send(f, 1'b1);
        end
        drain();
        check("err_sat", 64'(err_count), 64'd255);

        // Reset while a write to reg 3 sits in UPDATE
        send(16'h83AA, 1'b1);
        drain();
        check("pre_rst_reg3", 64'(en_pwm_hi), 64'hAA);
        send(16'h8377, 1'b0);
        rst         = 1'b1;
        frame_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_mid_reg3", 64'(en_pwm_hi), 64'd0);
        check("rst_mid_ready", 64'(frame_ready), 64'd1);
        check("rst_mid_wr", 64'(wr_pulse), 64'd0);
        @(negedge clk);
        check("rst_mid_regs", 64'(dut_flat()), 64'd0);
        check("rst_mid_pulses", 64'({wr_pulse, rd_valid, err_pulse}), 64'd0);
        check("rst_mid_err", 64'(err_count), 64'd0);

        // Randomized traffic, mostly back-to-back with valid held high
        for (int i = 0; i < 400; i++) begin
            f[15]   = 1'($urandom_range(0, 1));
            f[14:8] = ($urandom_range(0, 9) == 0) ? 7'(32'($urandom_range(5, 127)))
                                                  : 7'(32'($urandom_range(0, 5)));
            f[7:0]  = 8'($urandom);
            send(f, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                frame_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drain();
        check("final_regs", 64'(dut_flat()), 64'(model_flat()));
        check("final_err", 64'(err_count), 64'(m_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
